regfile_wb_arbiter: RTL and testbench

- Arbitrates the register file's single write port (wr, c_idx, c) among NREQ writeback sources, e.g. ALU result, load return and CSR/mul unit.
- Round-robin grant with a valid/ready handshake per requester.
- Winning request is registered and driven to the register file one cycle later.
- Exposes a pending-write bitmap so issue logic can detect in-flight writes.

---
 rtl/riscv_pkg.sv | 13 +
 rtl/regfile_wb_arbiter_if.sv | 15 +
 rtl/regfile_wb_arbiter_rr.sv | 27 ++
 rtl/regfile_wb_arbiter.sv | 71 +++++++
 tb/tb_regfile_wb_arbiter.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: register index and XLEN widths, writeback request bundle.
package riscv_pkg;
  localparam int REG_IDXW = 5;
  localparam int XLEN     = 32;

  typedef logic [REG_IDXW-1:0] reg_idx_t;

  typedef struct packed {
    logic            valid;
    reg_idx_t        idx;
    logic [XLEN-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bundle: per-requester valid/ready/idx/data plus the arbitration stall.
interface regfile_wb_arbiter_if #(
  parameter int NREQ  = 3,
  parameter int IDXW  = 5,
  parameter int WIDTH = 32
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*IDXW-1:0]  req_idx;
  logic [NREQ*WIDTH-1:0] req_data;
  logic                  stall;

  modport master (output req_valid, output req_idx, output req_data, output stall, input req_ready);
  modport slave  (input req_valid, input req_idx, input req_data, input stall, output req_ready);
endinterface

// File: rtl/regfile_wb_arbiter_rr.sv
// Combinational round-robin arbiter: search starts just after the last winner.
module rr_arbiter #(
  parameter int NREQ = 3,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  id
);
  always_comb begin
    int   j;
    logic found;
    gnt   = '0;
    id    = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      j = (int'(last) + k) % NREQ;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        id     = IDW'(j);
      end
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port among NREQ writeback sources, round-robin,
// with one registered output stage; x0 writes are accepted and discarded.
module regfile_wb_arbiter
  import riscv_pkg::*;
#(
  parameter int WIDTH = XLEN,
  parameter int NREQ  = 3,
  parameter int IDXW  = REG_IDXW,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rstn,
  regfile_wb_arbiter_if.slave  rq,
  output logic                 wr,
  output logic [IDXW-1:0]      c_idx,
  output logic [WIDTH-1:0]     c,
  output logic [2**IDXW-1:0]   pend,
  output logic [IDW-1:0]       grant_id
);
  logic [IDW-1:0]   last;
  logic [NREQ-1:0]  req_eff;
  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gid;
  logic             xfer;
  logic [IDXW-1:0]  sel_idx;
  logic [WIDTH-1:0] sel_data;
  logic             wr_q;

  assign req_eff = (rstn && !rq.stall) ? rq.req_valid : '0;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req  (req_eff),
    .last (last),
    .gnt  (gnt),
    .id   (gid)
  );

  assign rq.req_ready = gnt;
  assign xfer         = |gnt;
  assign sel_idx      = rq.req_idx[int'(gid)*IDXW +: IDXW];
  assign sel_data     = rq.req_data[int'(gid)*WIDTH +: WIDTH];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      last     <= IDW'(NREQ-1);
      wr_q     <= 1'b0;
      c_idx    <= '0;
      c        <= '0;
      grant_id <= '0;
    end else begin
      wr_q <= xfer && (sel_idx != '0);
      if (xfer) begin
        last <= gid;
        if (sel_idx != '0) begin
          c_idx    <= sel_idx;
          c        <= sel_data;
          grant_id <= gid;
        end
      end
    end
  end

  // Gating by rstn keeps a staged write from committing while reset is held.
  assign wr = wr_q & rstn;

  always_comb begin
    pend = '0;
    if (wr) pend[c_idx] = 1'b1;
    pend[0] = 1'b0;
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a small register file model on the write port.
module tb_regfile_wb_arbiter;
  logic        clk = 1'b0;
  logic        rstn;
  logic        wr;
  logic [4:0]  c_idx;
  logic [31:0] c;
  logic [31:0] pend;
  logic [1:0]  grant_id;
  logic [31:0] rf [32];
  int tests = 0;
  int fails = 0;

  regfile_wb_arbiter_if #(.NREQ(3), .IDXW(5), .WIDTH(32)) bus ();

  regfile_wb_arbiter #(.WIDTH(32), .NREQ(3), .IDXW(5)) dut (
    .clk(clk), .rstn(rstn), .rq(bus.slave),
    .wr(wr), .c_idx(c_idx), .c(c), .pend(pend), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 32; i++) rf[i] = 32'h0;
  always @(posedge clk) if (wr) rf[c_idx] <= c;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [4:0] idx, input logic [31:0] d);
    bus.req_valid[i]        = v;
    bus.req_idx[i*5 +: 5]   = idx;
    bus.req_data[i*32 +: 32] = d;
  endtask

  task automatic clear_reqs();
    bus.req_valid = '0;
    bus.req_idx   = '0;
    bus.req_data  = '0;
    bus.stall     = 1'b0;
  endtask

  task automatic do_reset();
    clear_reqs();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    clear_reqs();
    rstn = 1'b0;
    bus.req_valid = 3'b111;
    tick();
    tick();
    tests++; if (bus.req_ready !== 3'b000) begin fails++; $display("FAIL reset_ready got=%b exp=000", bus.req_ready); end
    tests++; if (wr !== 1'b0 || pend !== 32'h0) begin fails++; $display("FAIL reset_wr_pend got wr=%b pend=%h exp 0/0", wr, pend); end
    tests++; if (c_idx !== 5'd0 || c !== 32'h0 || grant_id !== 2'd0) begin fails++; $display("FAIL reset_outs got idx=%0d c=%h gid=%0d exp 0", c_idx, c, grant_id); end
    bus.req_valid = '0;
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++; if (wr !== 1'b0 || pend !== 32'h0 || bus.req_ready !== 3'b000) begin fails++; $display("FAIL idle_%0d got wr=%b pend=%h rdy=%b exp 0", k, wr, pend, bus.req_ready); end
    end
  endtask

  task automatic test_single();
    do_reset();
    set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    tests++; if (bus.req_ready !== 3'b001) begin fails++; $display("FAIL single_ready got=%b exp=001", bus.req_ready); end
    tick();
    set_req(0, 1'b0, 5'd0, 32'h0);
    tests++; if (wr !== 1'b1 || c_idx !== 5'd5 || c !== 32'hDEADBEEF) begin fails++; $display("FAIL single_out got wr=%b idx=%0d c=%h exp 1/5/deadbeef", wr, c_idx, c); end
    tests++; if (pend !== 32'h20 || grant_id !== 2'd0) begin fails++; $display("FAIL single_pend got pend=%h gid=%0d exp 20/0", pend, grant_id); end
    tick();
    tests++; if (wr !== 1'b0 || pend !== 32'h0 || c_idx !== 5'd5) begin fails++; $display("FAIL single_drain got wr=%b pend=%h idx=%0d exp 0/0/5", wr, pend, c_idx); end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_rdy [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    logic [4:0] exp_idx [6] = '{5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd3};
    logic [1:0] exp_gid [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    logic [31:0] exp_c [6] = '{32'hA1, 32'hA2, 32'hA3, 32'hA1, 32'hA2, 32'hA3};
    do_reset();
    set_req(0, 1'b1, 5'd1, 32'hA1);
    set_req(1, 1'b1, 5'd2, 32'hA2);
    set_req(2, 1'b1, 5'd3, 32'hA3);
    for (int k = 0; k < 6; k++) begin
      #1;
      tests++; if (bus.req_ready !== exp_rdy[k]) begin fails++; $display("FAIL rr_ready_%0d got=%b exp=%b", k, bus.req_ready, exp_rdy[k]); end
      tick();
      tests++; if (wr !== 1'b1 || c_idx !== exp_idx[k] || c !== exp_c[k] || grant_id !== exp_gid[k]) begin
        fails++; $display("FAIL rr_out_%0d got wr=%b idx=%0d c=%h gid=%0d exp 1/%0d/%h/%0d", k, wr, c_idx, c, grant_id, exp_idx[k], exp_c[k], exp_gid[k]);
      end
    end
    clear_reqs();
  endtask

  task automatic test_x0();
    do_reset();
    set_req(1, 1'b1, 5'd0, 32'h1234);
    #1;
    tests++; if (bus.req_ready !== 3'b010) begin fails++; $display("FAIL x0_ready got=%b exp=010", bus.req_ready); end
    tick();
    set_req(1, 1'b0, 5'd0, 32'h0);
    set_req(0, 1'b1, 5'd4, 32'h44);
    set_req(2, 1'b1, 5'd9, 32'h99);
    #1;
    tests++; if (wr !== 1'b0 || pend !== 32'h0) begin fails++; $display("FAIL x0_nowrite got wr=%b pend=%h exp 0/0", wr, pend); end
    tests++; if (bus.req_ready !== 3'b100) begin fails++; $display("FAIL x0_next_ready got=%b exp=100", bus.req_ready); end
    tick();
    clear_reqs();
    tests++; if (wr !== 1'b1 || c_idx !== 5'd9 || grant_id !== 2'd2 || pend !== 32'h200) begin fails++; $display("FAIL x0_next_out got wr=%b idx=%0d gid=%0d pend=%h exp 1/9/2/200", wr, c_idx, grant_id, pend); end
  endtask

  task automatic test_stall();
    do_reset();
    set_req(0, 1'b1, 5'd1, 32'hB1);
    set_req(1, 1'b1, 5'd2, 32'hB2);
    set_req(2, 1'b1, 5'd3, 32'hB3);
    #1;
    tests++; if (bus.req_ready !== 3'b001) begin fails++; $display("FAIL stall_first_ready got=%b exp=001", bus.req_ready); end
    tick();
    bus.stall = 1'b1;
    #1;
    tests++; if (wr !== 1'b1 || c_idx !== 5'd1 || bus.req_ready !== 3'b000) begin fails++; $display("FAIL stall_drain got wr=%b idx=%0d rdy=%b exp 1/1/000", wr, c_idx, bus.req_ready); end
    for (int k = 0; k < 3; k++) begin
      tick();
      if (k == 2) bus.stall = 1'b0;
      tests++; if (wr !== 1'b0 || (k < 2 && bus.req_ready !== 3'b000)) begin fails++; $display("FAIL stall_hold_%0d got wr=%b rdy=%b exp 0/000", k, wr, bus.req_ready); end
    end
    #1;
    tests++; if (bus.req_ready !== 3'b010) begin fails++; $display("FAIL stall_resume_ready got=%b exp=010", bus.req_ready); end
    tick();
    clear_reqs();
    tests++; if (wr !== 1'b1 || c_idx !== 5'd2 || grant_id !== 2'd1) begin fails++; $display("FAIL stall_resume_out got wr=%b idx=%0d gid=%0d exp 1/2/1", wr, c_idx, grant_id); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_req(0, 1'b1, 5'd5, 32'hBADC0DE5);
    #1;
    tests++; if (bus.req_ready !== 3'b001) begin fails++; $display("FAIL rstmid_ready got=%b exp=001", bus.req_ready); end
    tick();
    clear_reqs();
    rstn = 1'b0;
    #1;
    tests++; if (wr !== 1'b0) begin fails++; $display("FAIL rstmid_wr got=%b exp=0", wr); end
    tick();
    rstn = 1'b1;
    tick();
    tick();
    tests++; if (wr !== 1'b0 || rf[5] !== 32'hDEADBEEF) begin fails++; $display("FAIL rstmid_rf5 got wr=%b rf5=%h exp 0/deadbeef", wr, rf[5]); end
  endtask

  initial begin
    rstn = 1'b0;
    clear_reqs();
    test_reset();
    test_single();
    test_round_robin();
    test_x0();
    test_stall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
